// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter with completion-edge ack and optional watchdog
module uart_tx_arbiter #(
  parameter int NBIT_DATA_LEN = 8,
  parameter int N_REQ = 2,
  parameter int TIMEOUT = 0,
  parameter int NBIT_CNT = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_REQ-1:0]               req,
  input  logic [N_REQ*NBIT_DATA_LEN-1:0] req_data,
  output logic [N_REQ-1:0]               ack,
  output logic                           err,
  output logic                           busy,
  output logic [2:0]                     grant_id,
  output logic                           tx_start,
  output logic [NBIT_DATA_LEN-1:0]       data_out,
  input  logic                           tx_done_tick
);
  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, ACK} state_t;
  localparam logic [NBIT_CNT-1:0] TO_LAST = NBIT_CNT'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
  state_t state_q, state_d;
  logic [2:0] ptr_q, ptr_d, gid_q, gid_d, sel;
  logic [NBIT_DATA_LEN-1:0] data_q, data_d;
  logic [NBIT_CNT-1:0] cnt_q, cnt_d;
  logic tx_done_q, done_edge, timeout, found;
  assign done_edge = tx_done_tick & ~tx_done_q;
  assign timeout = (TIMEOUT != 0) && state_q == WAIT_DONE && !done_edge && cnt_q == TO_LAST;
  assign err = timeout;
  assign ack = (state_q == ACK || timeout) ? ONE << gid_q : '0;
  assign busy = state_q != IDLE;
  assign tx_start = state_q == START;
  assign grant_id = gid_q;
  assign data_out = data_q;
  always_comb begin
    sel = '0;
    found = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[(int'(ptr_q) + k) % N_REQ]) begin
        sel = 3'((int'(ptr_q) + k) % N_REQ);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    gid_d = gid_q;
    data_d = data_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (found) begin
        data_d = req_data[int'(sel)*NBIT_DATA_LEN +: NBIT_DATA_LEN];
        gid_d = sel;
        ptr_d = sel;
        state_d = START;
      end
      START: begin
        cnt_d = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        state_d = done_edge ? ACK : timeout ? IDLE : WAIT_DONE;
        cnt_d = (done_edge || timeout) ? cnt_q : cnt_q + NBIT_CNT'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= 3'(N_REQ - 1);
      gid_q <= '0;
      data_q <= '0;
      cnt_q <= '0;
      tx_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gid_q <= gid_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
      tx_done_q <= tx_done_tick;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of grant order, latency, level done, watchdog and mid-transfer reset
module tb_uart_tx_arbiter;
  logic clk = 0, reset = 1, tx_done_tick = 0;
  logic [1:0] req = 0, ack;
  logic [15:0] req_data = 0;
  logic err, busy, tx_start;
  logic [2:0] grant_id;
  logic [7:0] data_out;
  int vectors = 0, errs = 0;
  uart_tx_arbiter #(.NBIT_DATA_LEN(8), .N_REQ(2), .TIMEOUT(20), .NBIT_CNT(16)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack), .err(err),
    .busy(busy), .grant_id(grant_id), .tx_start(tx_start), .data_out(data_out),
    .tx_done_tick(tx_done_tick));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset;
    reset = 1;
    req = 0;
    tx_done_tick = 0;
    tick;
    tick;
    reset = 0;
  endtask
  task automatic xfer(input int id, input logic [7:0] d, input int w, input logic [1:0] req_after);
    tick;
    chk("tx_start", tx_start, 1);
    chk("grant_id", grant_id, id);
    chk("data_out", data_out, d);
    chk("busy_start", busy, 1);
    chk("ack_start", ack, 0);
    tick;
    chk("tx_start_once", tx_start, 0);
    repeat (w - 1) tick;
    tx_done_tick = 1;
    chk("ack_pre", ack, 0);
    tick;
    chk("ack", ack, 2'b01 << id);
    chk("err_ack", err, 0);
    chk("tx_start_ack", tx_start, 0);
    tx_done_tick = 0;
    req = req_after;
    tick;
    chk("busy_idle", busy, 0);
    chk("ack_idle", ack, 0);
  endtask
  initial begin
    do_reset;
    chk("rst_busy", busy, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_data", data_out, 0);
    chk("rst_grant", grant_id, 0);
    req = 2'b01;
    req_data = 16'h003C;
    xfer(0, 8'h3C, 10, 2'b00);
    req_data = 16'h00FF;
    tick;
    chk("data_hold", data_out, 8'h3C);
    do_reset;
    req = 2'b11;
    req_data = 16'h5AA5;
    xfer(0, 8'hA5, 3, 2'b10);
    xfer(1, 8'h5A, 3, 2'b00);
    do_reset;
    req = 2'b11;
    xfer(0, 8'hA5, 2, 2'b10);
    req = 2'b11;
    xfer(1, 8'h5A, 2, 2'b11);
    xfer(0, 8'hA5, 2, 2'b10);
    req = 2'b11;
    xfer(1, 8'h5A, 2, 2'b00);
    req = 2'b01;
    tick;
    chk("to_tx_start", tx_start, 1);
    req = 2'b00;
    tick;
    repeat (18) tick;
    chk("to_ack_early", ack, 0);
    chk("to_err_early", err, 0);
    tick;
    chk("to_ack", ack, 2'b01);
    chk("to_err", err, 1);
    chk("to_busy", busy, 1);
    tick;
    chk("to_idle", busy, 0);
    chk("to_ack_after", ack, 0);
    chk("to_err_after", err, 0);
    do_reset;
    req = 2'b11;
    tick;
    chk("lvl_grant0", grant_id, 0);
    req = 2'b10;
    tick;
    tick;
    tx_done_tick = 1;
    tick;
    chk("lvl_ack0", ack, 2'b01);
    tick;
    chk("lvl_ack_held", ack, 0);
    chk("lvl_idle", busy, 0);
    tick;
    chk("lvl_start1", tx_start, 1);
    chk("lvl_grant1", grant_id, 1);
    tick;
    chk("lvl_no_ack_w1", ack, 0);
    tx_done_tick = 0;
    tick;
    chk("lvl_no_ack_w2", ack, 0);
    tick;
    chk("lvl_no_ack_w3", ack, 0);
    chk("lvl_busy", busy, 1);
    tx_done_tick = 1;
    tick;
    chk("lvl_ack1", ack, 2'b10);
    chk("lvl_err1", err, 0);
    tx_done_tick = 0;
    req = 0;
    tick;
    req = 2'b01;
    tick;
    tick;
    tick;
    reset = 1;
    req = 0;
    tick;
    chk("mrst_ack", ack, 0);
    chk("mrst_err", err, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_tx_start", tx_start, 0);
    chk("mrst_data", data_out, 0);
    chk("mrst_grant", grant_id, 0);
    reset = 0;
    req = 2'b10;
    xfer(1, 8'h5A, 4, 2'b00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
